runtime_load_table: RTL and testbench

- Per-column instruction table for the CGRA control path.
- An AXI4 read master (read-only) streams instruction words from HBM into one column's table per transfer.
- After loading, each column's table is read by its own 12-bit program counter, which supplies that column's instruction word.
- Also provides a free-running cycle register.

---
 rtl/rlt_pkg.sv | 29 ++
 rtl/rlt_col_table.sv | 69 ++++++
 rtl/runtime_load_table.sv | 135 +++++++++++++
 tb/tb_runtime_load_table.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rlt_pkg.sv
// Shared constants, FSM state type and burst-length helper for runtime_load_table.
// Used by both the top level and the per-column table (see RLT_INSTR_OUTREG_EN in the top).
package rlt_pkg;

    localparam int NUM_COL     = 2;
    localparam int DWIDTH_INT  = 32;
    localparam int PC_WIDTH    = 12;
    localparam int TABLE_DEPTH = 4096;
    localparam int BEAT_BYTES  = 64;
    localparam int MAX_BURST   = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    // Beats needed for a byte count, clamped to one AXI burst, minus one.
    // A zero-byte request wraps to 255, i.e. a full burst.
    function automatic logic [7:0] burst_len(input logic [63:0] bytes);
        logic [63:0] beats;
        beats = (bytes >> $clog2(BEAT_BYTES)) + {63'd0, |bytes[$clog2(BEAT_BYTES)-1:0]};
        if (beats > 64'(MAX_BURST)) begin
            return 8'(MAX_BURST - 1);
        end
        return 8'(beats - 64'd1);
    endfunction

endpackage

// File: rtl/rlt_col_table.sv
// One CGRA column: instruction RAM, program counter and synchronous read port.
// With RLT_INSTR_OUTREG_EN defined an extra output register adds one cycle of read latency.
module rlt_col_table
    import rlt_pkg::*;
#(
    parameter int DATA_W = DWIDTH_INT,
    parameter int DEPTH  = TABLE_DEPTH,
    parameter int PC_W   = PC_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [PC_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clken,
    input  logic              load,
    input  logic              incr,
    input  logic [PC_W-1:0]   load_value,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] instr
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] instr_p1;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Load wins over stepping; the PC wraps naturally at its width.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_value;
        end else if (incr || clken) begin
            pc <= pc + 1'b1;
        end
    end

    // Read stage: a same-cycle write to this address returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_p1 <= '0;
        end else begin
            instr_p1 <= mem[pc];
        end
    end

`ifdef RLT_INSTR_OUTREG_EN
    logic [DATA_W-1:0] instr_p2;

    // Output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_p2 <= '0;
        end else begin
            instr_p2 <= instr_p1;
        end
    end

    assign instr = instr_p2;
`else
    assign instr = instr_p1;
`endif

endmodule

// File: rtl/runtime_load_table.sv
// Per-column CGRA instruction tables loaded over a read-only AXI4 master, plus a cycle counter.
// Define RLT_INSTR_OUTREG_EN to register instr once more (2-cycle read latency instead of 1).
module runtime_load_table
    import rlt_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_XFER_SIZE_WIDTH  = 64,
    parameter int num_col            = 2,
    parameter int dwidth_int         = 32,
    parameter int TABLE_DEPTH        = 4096
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            ctrl_start,
    output logic                            ctrl_done,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   ctrl_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0]    ctrl_xfer_size_in_bytes,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]                      m_axi_arlen,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic                            m_axi_rlast,
    input  logic [num_col-1:0]              clken_PC,
    input  logic [num_col-1:0]              load_PC,
    input  logic [num_col-1:0]              incr_PC,
    input  logic [num_col*PC_WIDTH-1:0]     load_value_PC,
    output logic [num_col*PC_WIDTH-1:0]     PC,
    output logic [dwidth_int-1:0]           cycle_register,
    output logic [num_col*dwidth_int-1:0]   instr
);

    localparam int PC_W  = PC_WIDTH;
    localparam int COL_W = (num_col > 1) ? $clog2(num_col) : 1;

    state_t            state;
    logic [COL_W-1:0]  col;
    logic [PC_W-1:0]   wptr;
    logic              beat;
    logic              we;
    logic              unused_rdata;

    // The column is encoded in the 8-byte-granular bits just above the word offset.
    function automatic logic [COL_W-1:0] col_of(input logic [C_M_AXI_ADDR_WIDTH-1:0] addr);
        if (num_col > 1) begin
            return addr[3 +: COL_W];
        end
        return '0;
    endfunction

    assign beat         = (state == ST_BUSY) && m_axi_rvalid && m_axi_rready;
    assign we           = beat && !areset;
    assign unused_rdata = ^m_axi_rdata[C_M_AXI_DATA_WIDTH-1:dwidth_int];

    always_ff @(posedge aclk) begin
        if (areset) begin
            state         <= ST_IDLE;
            ctrl_done     <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            col           <= '0;
            wptr          <= '0;
        end else begin
            ctrl_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ctrl_start) begin
                        state         <= ST_BUSY;
                        col           <= col_of(ctrl_addr_offset);
                        m_axi_araddr  <= ctrl_addr_offset;
                        m_axi_arlen   <= burst_len(64'(ctrl_xfer_size_in_bytes));
                        m_axi_arvalid <= 1'b1;
                        m_axi_rready  <= 1'b1;
                        wptr          <= '0;
                    end
                end
                ST_BUSY: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                    end
                    // R is accepted independently of the AR handshake.
                    if (beat) begin
                        wptr <= wptr + 1'b1;
                        if (m_axi_rlast) begin
                            state         <= ST_DONE;
                            m_axi_arvalid <= 1'b0;
                            m_axi_rready  <= 1'b0;
                            ctrl_done     <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset || (state == ST_IDLE && ctrl_start)) begin
            cycle_register <= '0;
        end else begin
            cycle_register <= cycle_register + 1'b1;
        end
    end

    for (genvar c = 0; c < num_col; c++) begin : g_col
        rlt_col_table #(
            .DATA_W (dwidth_int),
            .DEPTH  (TABLE_DEPTH),
            .PC_W   (PC_W)
        ) u_table (
            .clk        (aclk),
            .rst        (areset),
            .we         (we && (col == COL_W'(c))),
            .waddr      (wptr),
            .wdata      (m_axi_rdata[dwidth_int-1:0]),
            .clken      (clken_PC[c]),
            .load       (load_PC[c]),
            .incr       (incr_PC[c]),
            .load_value (load_value_PC[c*PC_W +: PC_W]),
            .pc         (PC[c*PC_W +: PC_W]),
            .instr      (instr[c*dwidth_int +: dwidth_int])
        );
    end

endmodule

// File: tb/tb_runtime_load_table.sv
// Scoreboard bench for runtime_load_table: a cycle model queues expected outputs, a monitor compares them.
// Honours RLT_INSTR_OUTREG_EN for the instr read latency.
module tb_runtime_load_table;

    localparam int NC    = 2;
    localparam int DW    = 32;
    localparam int PW    = 12;
    localparam int DEPTH = 4096;
`ifdef RLT_INSTR_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              aclk = 1'b0;
    logic              areset;
    logic              ctrl_start;
    logic              ctrl_done;
    logic [63:0]       ctrl_addr_offset;
    logic [63:0]       ctrl_xfer_size_in_bytes;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [63:0]       m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic              m_axi_rvalid;
    logic              m_axi_rready;
    logic [511:0]      m_axi_rdata;
    logic              m_axi_rlast;
    logic [NC-1:0]     clken_PC;
    logic [NC-1:0]     load_PC;
    logic [NC-1:0]     incr_PC;
    logic [NC*PW-1:0]  load_value_PC;
    logic [NC*PW-1:0]  PC;
    logic [DW-1:0]     cycle_register;
    logic [NC*DW-1:0]  instr;

    always #5 aclk = ~aclk;

    runtime_load_table dut (
        .aclk                    (aclk),
        .areset                  (areset),
        .ctrl_start              (ctrl_start),
        .ctrl_done               (ctrl_done),
        .ctrl_addr_offset        (ctrl_addr_offset),
        .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
        .m_axi_arvalid           (m_axi_arvalid),
        .m_axi_arready           (m_axi_arready),
        .m_axi_araddr            (m_axi_araddr),
        .m_axi_arlen             (m_axi_arlen),
        .m_axi_rvalid            (m_axi_rvalid),
        .m_axi_rready            (m_axi_rready),
        .m_axi_rdata             (m_axi_rdata),
        .m_axi_rlast             (m_axi_rlast),
        .clken_PC                (clken_PC),
        .load_PC                 (load_PC),
        .incr_PC                 (incr_PC),
        .load_value_PC           (load_value_PC),
        .PC                      (PC),
        .cycle_register          (cycle_register),
        .instr                   (instr)
    );

    typedef struct packed {
        logic          arv;
        logic [63:0]   addr;
        logic [7:0]    len;
        logic          rr;
        logic          done;
        logic [31:0]   cyc_reg;
        logic [NC*PW-1:0] pc;
        logic [NC*DW-1:0] ins;
        logic [NC-1:0] known;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   rand_pc = 0;

    // Reference state
    logic [31:0]     tbl [NC][DEPTH];
    bit              wr  [NC][DEPTH];
    int              m_pc [NC];
    logic [31:0]     rd_now [NC];
    logic [31:0]     rd_prev [NC];
    bit              k_now [NC];
    bit              k_prev [NC];
    bit              m_busy, m_arv, m_done;
    logic [63:0]     m_addr;
    logic [7:0]      m_len;
    int              m_col, m_wptr;
    logic [31:0]     m_cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_len(input longint unsigned bytes);
        longint unsigned beats;
        beats = bytes / 64 + ((bytes % 64) != 0 ? 1 : 0);
        if (beats > 256) beats = 256;
        return 8'((beats + 255) % 256);
    endfunction

    always @(posedge aclk) begin
        exp_t e;
        bit   acc;
        cyc++;
        // Synchronous read sees the PC and table contents from before this edge.
        for (int c = 0; c < NC; c++) begin
            if (areset) begin
                rd_prev[c] = '0; k_prev[c] = 1;
                rd_now[c]  = '0; k_now[c]  = 1;
            end else begin
                rd_prev[c] = rd_now[c]; k_prev[c] = k_now[c];
                rd_now[c]  = tbl[c][m_pc[c]];
                k_now[c]   = wr[c][m_pc[c]];
            end
        end
        if (areset) begin
            m_busy = 0; m_arv = 0; m_done = 0; m_cyc = '0;
            m_addr = '0; m_len = '0;
            for (int c = 0; c < NC; c++) m_pc[c] = 0;
        end else begin
            acc   = ctrl_start && !m_busy && !m_done;
            m_cyc = acc ? 32'd0 : m_cyc + 32'd1;
            m_done = 0;
            if (m_busy) begin
                if (m_axi_arready) m_arv = 0;
                if (m_axi_rvalid) begin
                    tbl[m_col][m_wptr] = m_axi_rdata[31:0];
                    wr[m_col][m_wptr]  = 1;
                    m_wptr = (m_wptr + 1) % DEPTH;
                    if (m_axi_rlast) begin
                        m_busy = 0; m_arv = 0; m_done = 1;
                    end
                end
            end else if (acc) begin
                m_busy = 1; m_arv = 1;
                m_addr = ctrl_addr_offset;
                m_len  = exp_len(ctrl_xfer_size_in_bytes);
                m_col  = int'(ctrl_addr_offset[3]);
                m_wptr = 0;
            end
            for (int c = 0; c < NC; c++) begin
                if (load_PC[c]) m_pc[c] = int'(load_value_PC[c*PW +: PW]);
                else if (incr_PC[c] || clken_PC[c]) m_pc[c] = (m_pc[c] + 1) % DEPTH;
            end
        end
        e.arv = m_arv; e.addr = m_addr; e.len = m_len;
        e.rr = m_busy; e.done = m_done; e.cyc_reg = m_cyc;
        for (int c = 0; c < NC; c++) begin
            e.pc[c*PW +: PW] = PW'(m_pc[c]);
            e.ins[c*DW +: DW] = (LAT == 1) ? rd_now[c] : rd_prev[c];
            e.known[c]        = (LAT == 1) ? k_now[c]  : k_prev[c];
        end
        q.push_back(e);
    end

    always @(negedge aclk) begin
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            check("arvalid", 64'(m_axi_arvalid), 64'(e.arv));
            if (e.arv) begin
                check("araddr", m_axi_araddr, e.addr);
                check("arlen", 64'(m_axi_arlen), 64'(e.len));
            end
            check("rready", 64'(m_axi_rready), 64'(e.rr));
            check("ctrl_done", 64'(ctrl_done), 64'(e.done));
            check("cycle_register", 64'(cycle_register), 64'(e.cyc_reg));
            check("PC", 64'(PC), 64'(e.pc));
            for (int c = 0; c < NC; c++) begin
                if (e.known[c]) check($sformatf("instr%0d", c), 64'(instr[c*DW +: DW]), 64'(e.ins[c*DW +: DW]));
            end
        end
    end

    task automatic tick();
        @(posedge aclk); #1;
        if (rand_pc) begin
            for (int c = 0; c < NC; c++) begin
                clken_PC[c] = ($urandom_range(0, 5) == 0);
                incr_PC[c]  = ($urandom_range(0, 3) == 0);
                load_PC[c]  = ($urandom_range(0, 9) == 0);
                load_value_PC[c*PW +: PW] = ($urandom_range(0, 7) == 0) ? 12'd4095 : 12'($urandom_range(0, 15));
            end
        end
    endtask

    task automatic start(input logic [63:0] off, input logic [63:0] size);
        ctrl_start = 1; ctrl_addr_offset = off; ctrl_xfer_size_in_bytes = size;
        tick();
        ctrl_start = 0;
    endtask

    task automatic beat(input logic [31:0] data, input bit last);
        for (int i = 0; i < 16; i++) m_axi_rdata[i*32 +: 32] = $urandom;
        m_axi_rdata[31:0] = data;
        m_axi_rvalid = 1; m_axi_rlast = last;
        tick();
        m_axi_rvalid = 0; m_axi_rlast = 0;
    endtask

    task automatic step_check(input logic [NC*PW-1:0] epc, input logic [NC*DW-1:0] eins, input bit chk_ins);
        incr_PC = '1;
        tick();
        incr_PC = '0;
        repeat (LAT) tick();
        @(negedge aclk);
        check("plan_pc_step", 64'(PC), 64'(epc));
        if (chk_ins) check("plan_instr_step", 64'(instr), 64'(eins));
    endtask

    initial begin
        logic [31:0] pat0 [4];
        logic [31:0] pat1 [4];
        pat0 = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        pat1 = '{32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
        areset = 1; ctrl_start = 0; ctrl_addr_offset = '0; ctrl_xfer_size_in_bytes = '0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rlast = 0;
        clken_PC = '0; load_PC = '0; incr_PC = '0; load_value_PC = '0;
        repeat (3) tick();
        areset = 0;
        tick();

        start(64'h0, 64'hFF);
        @(negedge aclk);
        check("plan_arvalid", 64'(m_axi_arvalid), 64'd1);
        check("plan_araddr", m_axi_araddr, 64'd0);
        check("plan_arlen", 64'(m_axi_arlen), 64'd3);
        for (int i = 0; i < 4; i++) begin
            beat(pat0[i], i == 3);
            if (i == 3) begin
                @(negedge aclk);
                check("plan_done_pulse", 64'(ctrl_done), 64'd1);
            end
        end
        repeat (3) tick();

        start(64'h8, 64'hFF);
        for (int i = 0; i < 4; i++) beat(pat1[i], i == 3);
        repeat (3) tick();

        load_PC = 2'b11; load_value_PC = '0;
        tick();
        load_PC = '0;
        repeat (LAT) tick();
        @(negedge aclk);
        check("plan_instr_pc0", 64'(instr), {32'h55555555, 32'h11111111});
        step_check({12'd1, 12'd1}, {32'h66666666, 32'h22222222}, 1);
        step_check({12'd2, 12'd2}, {32'h77777777, 32'h33333333}, 1);
        step_check({12'd3, 12'd3}, {32'h88888888, 32'h44444444}, 1);
        step_check({12'd4, 12'd4}, '0, 0);

        load_PC = 2'b11; load_value_PC = {12'd4095, 12'd4095};
        tick();
        load_PC = '0; incr_PC = 2'b11;
        tick();
        incr_PC = '0;
        @(negedge aclk);
        check("plan_pc_wrap", 64'(PC), 64'd0);
        load_PC = 2'b11; incr_PC = 2'b11; load_value_PC = {12'd7, 12'd5};
        tick();
        load_PC = '0; incr_PC = '0;
        @(negedge aclk);
        check("plan_load_priority", 64'(PC), 64'({12'd7, 12'd5}));

        // A second start while busy must not disturb the running load.
        start(64'h0, 64'd128);
        tick();
        start(64'h8, 64'd64);
        beat(32'hA0A0A0A0, 0);
        beat(32'hB1B1B1B1, 1);
        repeat (3) tick();

        start(64'h8, 64'd256);
        beat(32'hDEADBEEF, 0);
        areset = 1;
        tick();
        areset = 0;
        @(negedge aclk);
        check("plan_abort_rready", 64'(m_axi_rready), 64'd0);
        check("plan_abort_done", 64'(ctrl_done), 64'd0);
        repeat (3) tick();
        m_axi_arready = 1;
        start(64'h0, 64'd64);
        @(negedge aclk);
        check("plan_ar_before_hs", 64'(m_axi_arvalid), 64'd1);
        tick();
        @(negedge aclk);
        check("plan_ar_after_hs", 64'(m_axi_arvalid), 64'd0);
        beat(32'hC2C2C2C2, 1);
        repeat (2) tick();

        rand_pc = 1;
        for (int t = 0; t < 24; t++) begin
            logic [63:0] off;
            logic [63:0] size;
            int nb;
            off  = (64'($urandom) & 64'hFFFF_FFC0) | (64'($urandom_range(0, 1)) << 3);
            size = 64'($urandom_range(1, 700));
            nb   = int'(exp_len(size)) + 1;
            m_axi_arready = $urandom_range(0, 1);
            start(off, size);
            for (int b = 0; b < nb; b++) begin
                repeat ($urandom_range(0, 2)) begin
                    m_axi_arready = $urandom_range(0, 1);
                    tick();
                end
                if ($urandom_range(0, 7) == 0) begin
                    ctrl_start = 1;
                    ctrl_addr_offset = 64'($urandom);
                    ctrl_xfer_size_in_bytes = 64'($urandom_range(1, 4096));
                end
                beat($urandom, b == nb - 1);
                ctrl_start = 0;
            end
            repeat ($urandom_range(1, 4)) tick();
        end
        rand_pc = 0;
        clken_PC = '0; load_PC = '0; incr_PC = '0;
        repeat (4) tick();
        @(negedge aclk);
        #1;
        check("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
